// File: rtl/goertzel_pkg.sv
// Shared types and helpers for the time-multiplexed Goertzel engine.
//   state_e    : FSM state encoding used by goertzel_tdm.
//   COEF_FRAC  : fraction bits of the nominal Q2.16 coefficient (CW = 18).
//   sat_signed : clamp a wide signed value to the signed range of 'width' bits.
package goertzel_pkg;

  typedef enum logic [2:0] {StIdle, StAcc, StRun, StFin, StOut} state_e;

  localparam int unsigned CW_NOMINAL = 18;
  localparam int unsigned COEF_FRAC  = CW_NOMINAL - 2;

  function automatic logic signed [127:0] sat_signed(input logic signed [127:0] value,
                                                      input int unsigned width);
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    hi = (128'sd1 <<< (width - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/goertzel_mac.sv
// Combinational Goertzel datapath shared by the state update and the power stage.
// Optional feature macro: GOERTZEL_SAT_EN (saturate s0 and flag overflow; otherwise wrap).
// Ports:
//   x_i     : sample (signed, DW)           coef_i  : 2cos(w) in Q2.(CW-2)
//   s1_i    : state s[n-1] (signed, AW)     s2_i    : state s[n-2] (signed, AW)
//   s0_o    : next state s[n] (AW)          ovf_o   : s0 left the AW range (sat build only)
//   power_o : |X|^2 clamped to [0, 2^PW-1]
module goertzel_mac import goertzel_pkg::*; #(
  parameter int unsigned DW = 16,
  parameter int unsigned CW = 18,
  parameter int unsigned AW = 32,
  parameter int unsigned PW = 64
) (
  input  logic [DW-1:0] x_i,
  input  logic [CW-1:0] coef_i,
  input  logic [AW-1:0] s1_i,
  input  logic [AW-1:0] s2_i,
  output logic [AW-1:0] s0_o,
  output logic          ovf_o,
  output logic [PW-1:0] power_o
);

  localparam int unsigned CoefFrac = CW - 2;
  localparam int unsigned ProdW    = AW + CW;
  localparam int unsigned PowW     = 2 * AW + 2;
  localparam int unsigned ExtW     = ((PowW > PW) ? PowW : PW) + 1;

  logic signed [ProdW-1:0] prod;
  logic signed [ProdW-1:0] fb;

  assign prod = ProdW'($signed(coef_i)) * ProdW'($signed(s1_i));
  assign fb   = prod >>> CoefFrac;

`ifdef GOERTZEL_SAT_EN
  localparam int unsigned SumW = ProdW + 1;
  logic signed [SumW-1:0] sum;
  logic signed [127:0]    sum_wide;
  logic signed [127:0]    sum_sat;

  assign sum      = SumW'($signed(x_i)) + SumW'(fb) - SumW'($signed(s2_i));
  assign sum_wide = 128'(sum);
  assign sum_sat  = sat_signed(sum_wide, AW);
  assign s0_o     = sum_sat[AW-1:0];
  assign ovf_o    = (sum_sat != sum_wide);
`else
  // Modulo-2^AW arithmetic: only the low AW bits of every term matter.
  assign s0_o  = AW'($signed(x_i)) + fb[AW-1:0] - s2_i;
  assign ovf_o = 1'b0;
`endif

  logic signed [PowW-1:0] s1_w, s2_w, fb_w, p;
  logic signed [ExtW-1:0] p_ext, p_max;

  assign s1_w  = PowW'($signed(s1_i));
  assign s2_w  = PowW'($signed(s2_i));
  assign fb_w  = PowW'(fb);
  assign p     = s1_w * s1_w + s2_w * s2_w - fb_w * s2_w;
  assign p_ext = ExtW'(p);
  assign p_max = ExtW'({PW{1'b1}});

  always_comb begin
    power_o = p_ext[PW-1:0];
    if (p_ext < 0) begin
      power_o = '0;
    end else if (p_ext > p_max) begin
      power_o = '1;
    end
  end

endmodule

// File: rtl/goertzel_tdm.sv
// Time-multiplexed Goertzel power engine: NCH channels x NF bins share one MAC,
// one state slot per clock (slot = chan*NF + bin).
// Optional feature macro: GOERTZEL_SAT_EN (saturating states, sticky overflow).
// Ports:
//   clk, rst (async, active-high)
//   start, cfg_num_samp, cfg_coef       : frame control, latched on accepted start
//   s_valid, s_ready, s_data            : input sample vector stream
//   m_valid, m_ready, m_chan, m_bin, m_power : result stream
//   busy, frame_done, overflow          : status
module goertzel_tdm import goertzel_pkg::*; #(
  parameter int unsigned NCH = 2,
  parameter int unsigned NF  = 2,
  parameter int unsigned DW  = 16,
  parameter int unsigned CW  = 18,
  parameter int unsigned AW  = 32,
  parameter int unsigned PW  = 64,
  parameter int unsigned NSW = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [NSW-1:0]                        cfg_num_samp,
  input  logic [NF*CW-1:0]                      cfg_coef,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic [NCH*DW-1:0]                     s_data,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] m_chan,
  output logic [((NF > 1) ? $clog2(NF) : 1)-1:0]   m_bin,
  output logic [PW-1:0]                         m_power,
  output logic                                  busy,
  output logic                                  frame_done,
  output logic                                  overflow
);

  localparam int unsigned NS    = NCH * NF;
  localparam int unsigned SlotW = (NS > 1) ? $clog2(NS) : 1;
  localparam int unsigned ChW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned BinW  = (NF > 1) ? $clog2(NF) : 1;

  state_e            state_q;
  logic [NSW-1:0]    num_samp_q;
  logic [NSW-1:0]    samp_cnt_q;
  logic [NF*CW-1:0]  coef_q;
  logic [NCH*DW-1:0] x_q;
  logic [SlotW-1:0]  slot_q;
  logic [ChW-1:0]    chan_q;
  logic [BinW-1:0]   bin_q;
  logic [AW-1:0]     s1_q [NS];
  logic [AW-1:0]     s2_q [NS];

  logic [AW-1:0] s0;
  logic [PW-1:0] power;
  logic          ovf;
  logic          last_slot;
  logic          last_bin;

  assign last_slot = (slot_q == SlotW'(NS - 1));
  assign last_bin  = (bin_q == BinW'(NF - 1));

  goertzel_mac #(
    .DW(DW),
    .CW(CW),
    .AW(AW),
    .PW(PW)
  ) u_mac (
    .x_i    (x_q[chan_q*DW +: DW]),
    .coef_i (coef_q[bin_q*CW +: CW]),
    .s1_i   (s1_q[slot_q]),
    .s2_i   (s2_q[slot_q]),
    .s0_o   (s0),
    .ovf_o  (ovf),
    .power_o(power)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      num_samp_q <= '0;
      samp_cnt_q <= '0;
      coef_q     <= '0;
      x_q        <= '0;
      slot_q     <= '0;
      chan_q     <= '0;
      bin_q      <= '0;
      for (int i = 0; i < NS; i++) begin
        s1_q[i] <= '0;
        s2_q[i] <= '0;
      end
      s_ready    <= 1'b0;
      m_valid    <= 1'b0;
      m_chan     <= '0;
      m_bin      <= '0;
      m_power    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start && (cfg_num_samp != '0)) begin
            num_samp_q <= cfg_num_samp;
            coef_q     <= cfg_coef;
            samp_cnt_q <= '0;
            slot_q     <= '0;
            chan_q     <= '0;
            bin_q      <= '0;
            for (int i = 0; i < NS; i++) begin
              s1_q[i] <= '0;
              s2_q[i] <= '0;
            end
            overflow <= 1'b0;
            busy     <= 1'b1;
            s_ready  <= 1'b1;
            state_q  <= StAcc;
          end
        end
        StAcc: begin
          if (s_valid) begin
            x_q     <= s_data;
            s_ready <= 1'b0;
            state_q <= StRun;
          end
        end
        StRun: begin
          s1_q[slot_q] <= s0;
          s2_q[slot_q] <= s1_q[slot_q];
          if (ovf) overflow <= 1'b1;
          if (last_slot) begin
            slot_q     <= '0;
            chan_q     <= '0;
            bin_q      <= '0;
            samp_cnt_q <= samp_cnt_q + 1'b1;
            if (samp_cnt_q + 1'b1 == num_samp_q) begin
              state_q <= StFin;
            end else begin
              s_ready <= 1'b1;
              state_q <= StAcc;
            end
          end else begin
            slot_q <= slot_q + 1'b1;
            if (last_bin) begin
              bin_q  <= '0;
              chan_q <= chan_q + 1'b1;
            end else begin
              bin_q <= bin_q + 1'b1;
            end
          end
        end
        StFin: begin
          m_valid <= 1'b1;
          m_chan  <= chan_q;
          m_bin   <= bin_q;
          m_power <= power;
          state_q <= StOut;
        end
        StOut: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            if (last_slot) begin
              frame_done <= 1'b1;
              busy       <= 1'b0;
              slot_q     <= '0;
              chan_q     <= '0;
              bin_q      <= '0;
              for (int i = 0; i < NS; i++) begin
                s1_q[i] <= '0;
                s2_q[i] <= '0;
              end
              state_q <= StIdle;
            end else begin
              slot_q <= slot_q + 1'b1;
              if (last_bin) begin
                bin_q  <= '0;
                chan_q <= chan_q + 1'b1;
              end else begin
                bin_q <= bin_q + 1'b1;
              end
              state_q <= StFin;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_goertzel_tdm.sv
// Directed bench for goertzel_tdm: a 1x1 instance (AW=18) and a default 2x2 instance.
module tb_goertzel_tdm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

`ifdef GOERTZEL_SAT_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  // Instance A: NCH=1, NF=1, AW=18
  logic        a_start = 1'b0;
  logic [15:0] a_num = '0;
  logic [17:0] a_coef = '0;
  logic        a_s_valid = 1'b0;
  logic        a_s_ready;
  logic [15:0] a_s_data = '0;
  logic        a_m_valid;
  logic        a_m_ready = 1'b0;
  logic [0:0]  a_m_chan, a_m_bin;
  logic [63:0] a_m_power;
  logic        a_busy, a_frame_done, a_overflow;

  // Instance B: defaults NCH=2, NF=2, AW=32
  logic        b_start = 1'b0;
  logic [15:0] b_num = '0;
  logic [35:0] b_coef = '0;
  logic        b_s_valid = 1'b0;
  logic        b_s_ready;
  logic [31:0] b_s_data = '0;
  logic        b_m_valid;
  logic        b_m_ready = 1'b0;
  logic [0:0]  b_m_chan, b_m_bin;
  logic [63:0] b_m_power;
  logic        b_busy, b_frame_done, b_overflow;

  goertzel_tdm #(.NCH(1), .NF(1), .AW(18)) u_dut_a (
    .clk(clk), .rst(rst), .start(a_start), .cfg_num_samp(a_num), .cfg_coef(a_coef),
    .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
    .m_valid(a_m_valid), .m_ready(a_m_ready), .m_chan(a_m_chan), .m_bin(a_m_bin),
    .m_power(a_m_power), .busy(a_busy), .frame_done(a_frame_done), .overflow(a_overflow)
  );

  goertzel_tdm u_dut_b (
    .clk(clk), .rst(rst), .start(b_start), .cfg_num_samp(b_num), .cfg_coef(b_coef),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_chan(b_m_chan), .m_bin(b_m_bin),
    .m_power(b_m_power), .busy(b_busy), .frame_done(b_frame_done), .overflow(b_overflow)
  );

  logic [15:0] pulse_x [4] = '{16'd1, 16'd0, 16'hFFFF, 16'd0};
  logic [35:0] coef_01 = {18'h10000, 18'h00000};
  int          exp_chan [4] = '{0, 0, 1, 1};
  int          exp_bin [4] = '{0, 1, 0, 1};
  int          exp_pow [4] = '{4, 3, 0, 0};

  logic [0:0]  got_chan [4];
  logic [0:0]  got_bin [4];
  logic [63:0] got_pow [4];
  int          got_gap [4];
  int          got_n;
  logic        got_fd;
  logic        got_extra;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_start_frame(input logic [15:0] num, input logic [17:0] coef);
    a_num = num;
    a_coef = coef;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  task automatic b_start_frame(input logic [15:0] num, input logic [35:0] coef);
    b_num = num;
    b_coef = coef;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
  endtask

  task automatic a_send(input logic [15:0] xv);
    int n = 0;
    a_s_data = xv;
    a_s_valid = 1'b1;
    while (!a_s_ready && n < 200) begin
      tick();
      n++;
    end
    if (!a_s_ready) begin
      total++; bad++;
      $display("FAIL a_send_timeout s_ready=%0b required=1", a_s_ready);
    end
    tick();
    a_s_valid = 1'b0;
  endtask

  task automatic b_send(input logic [15:0] x0);
    int n = 0;
    b_s_data = {16'h0000, x0};
    b_s_valid = 1'b1;
    while (!b_s_ready && n < 200) begin
      tick();
      n++;
    end
    if (!b_s_ready) begin
      total++; bad++;
      $display("FAIL b_send_timeout s_ready=%0b required=1", b_s_ready);
    end
    tick();
    b_s_valid = 1'b0;
  endtask

  task automatic a_wait_valid();
    int n = 0;
    while (!a_m_valid && n < 400) begin
      tick();
      n++;
    end
    if (!a_m_valid) begin
      total++; bad++;
      $display("FAIL a_result_timeout m_valid=%0b required=1", a_m_valid);
    end
  endtask

  // Records results first..first+cnt-1 of instance B with m_ready held high.
  task automatic b_collect(input int first, input int cnt);
    int n;
    b_m_ready = 1'b1;
    for (int i = first; i < first + cnt; i++) begin
      n = 0;
      while (!b_m_valid && n < 400) begin
        tick();
        n++;
      end
      if (!b_m_valid) begin
        total++; bad++;
        $display("FAIL b_result_timeout index=%0d m_valid=0 required=1", i);
        return;
      end
      got_chan[i] = b_m_chan;
      got_bin[i] = b_m_bin;
      got_pow[i] = b_m_power;
      got_gap[i] = n;
      got_n++;
      tick();
    end
    got_fd = b_frame_done;
    got_extra = 1'b0;
    repeat (6) begin
      tick();
      if (b_m_valid || b_frame_done) got_extra = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total++;
    if ({a_busy, a_s_ready, a_m_valid, a_frame_done, a_overflow} !== 5'b0) begin
      bad++;
      $display("FAIL reset_a_flags got=%b required=00000",
               {a_busy, a_s_ready, a_m_valid, a_frame_done, a_overflow});
    end
    total++;
    if ({b_busy, b_s_ready, b_m_valid, b_frame_done, b_overflow} !== 5'b0) begin
      bad++;
      $display("FAIL reset_b_flags got=%b required=00000",
               {b_busy, b_s_ready, b_m_valid, b_frame_done, b_overflow});
    end
    total++;
    if (a_m_power !== 64'd0 || b_m_power !== 64'd0 || {a_m_chan, a_m_bin, b_m_chan, b_m_bin} !== 4'b0) begin
      bad++;
      $display("FAIL reset_fields a_pow=%0d b_pow=%0d required=0", a_m_power, b_m_power);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_pulse();
    a_m_ready = 1'b1;
    a_start_frame(16'd4, 18'h0);
    total++;
    if (a_busy !== 1'b1 || a_s_ready !== 1'b1) begin
      bad++;
      $display("FAIL pulse_start busy=%0b s_ready=%0b required=1,1", a_busy, a_s_ready);
    end
    for (int i = 0; i < 4; i++) a_send(pulse_x[i]);
    a_wait_valid();
    total++;
    if (a_m_power !== 64'd4 || a_m_chan !== 1'b0 || a_m_bin !== 1'b0) begin
      bad++;
      $display("FAIL pulse_result pow=%0d chan=%0d bin=%0d required=4,0,0",
               a_m_power, a_m_chan, a_m_bin);
    end
    tick();
    total++;
    if (a_frame_done !== 1'b1 || a_m_valid !== 1'b0) begin
      bad++;
      $display("FAIL pulse_frame_done fd=%0b m_valid=%0b required=1,0", a_frame_done, a_m_valid);
    end
    tick();
    total++;
    if (a_frame_done !== 1'b0 || a_busy !== 1'b0) begin
      bad++;
      $display("FAIL pulse_done_width fd=%0b busy=%0b required=0,0", a_frame_done, a_busy);
    end
  endtask

  task automatic test_single_dc();
    a_start_frame(16'd4, 18'h0);
    for (int i = 0; i < 4; i++) a_send(16'd1);
    a_wait_valid();
    total++;
    if (a_m_power !== 64'd0) begin
      bad++;
      $display("FAIL dc_result pow=%0d required=0", a_m_power);
    end
    tick();
    total++;
    if (a_frame_done !== 1'b1) begin
      bad++;
      $display("FAIL dc_frame_done fd=%0b required=1", a_frame_done);
    end
    tick();
  endtask

  task automatic test_multi();
    got_n = 0;
    b_start_frame(16'd4, coef_01);
    for (int i = 0; i < 4; i++) b_send(pulse_x[i]);
    b_collect(0, 4);
    total++;
    if (got_n !== 4) begin
      bad++;
      $display("FAIL multi_count got=%0d required=4", got_n);
    end
    for (int i = 0; i < got_n; i++) begin
      total++;
      if (got_chan[i] !== 1'(exp_chan[i]) || got_bin[i] !== 1'(exp_bin[i]) ||
          got_pow[i] !== 64'(exp_pow[i])) begin
        bad++;
        $display("FAIL multi_result%0d got=(%0d,%0d,%0d) required=(%0d,%0d,%0d)", i,
                 got_chan[i], got_bin[i], got_pow[i], exp_chan[i], exp_bin[i], exp_pow[i]);
      end
    end
    for (int i = 1; i < got_n; i++) begin
      total++;
      if (got_gap[i] !== 1) begin
        bad++;
        $display("FAIL multi_gap%0d idle=%0d required=1", i, got_gap[i]);
      end
    end
    total++;
    if (got_fd !== 1'b1 || got_extra !== 1'b0) begin
      bad++;
      $display("FAIL multi_tail fd=%0b extra=%0b required=1,0", got_fd, got_extra);
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    logic steady = 1'b1;
    got_n = 0;
    b_m_ready = 1'b0;
    b_start_frame(16'd4, coef_01);
    for (int i = 0; i < 4; i++) b_send(pulse_x[i]);
    while (!b_m_valid && n < 400) begin
      tick();
      n++;
    end
    repeat (10) begin
      total++;
      if (b_m_valid !== 1'b1 || b_m_chan !== 1'b0 || b_m_bin !== 1'b0 || b_m_power !== 64'd4) begin
        bad++;
        steady = 1'b0;
        $display("FAIL bp_hold valid=%0b chan=%0d bin=%0d pow=%0d required=1,0,0,4",
                 b_m_valid, b_m_chan, b_m_bin, b_m_power);
      end
      tick();
    end
    got_n = 1;
    b_m_ready = 1'b1;
    tick();
    b_collect(1, 3);
    total++;
    if (got_n !== 4) begin
      bad++;
      $display("FAIL bp_count got=%0d required=4", got_n);
    end
    for (int i = 1; i < got_n; i++) begin
      total++;
      if (got_chan[i] !== 1'(exp_chan[i]) || got_bin[i] !== 1'(exp_bin[i]) ||
          got_pow[i] !== 64'(exp_pow[i])) begin
        bad++;
        $display("FAIL bp_result%0d got=(%0d,%0d,%0d) required=(%0d,%0d,%0d)", i,
                 got_chan[i], got_bin[i], got_pow[i], exp_chan[i], exp_bin[i], exp_pow[i]);
      end
    end
    total++;
    if (got_fd !== 1'b1 || got_extra !== 1'b0) begin
      bad++;
      $display("FAIL bp_tail fd=%0b extra=%0b required=1,0 steady=%0b", got_fd, got_extra, steady);
    end
  endtask

  task automatic test_config_edges();
    logic seen = 1'b0;
    b_start_frame(16'd0, coef_01);
    repeat (4) begin
      if (b_busy || b_s_ready || b_m_valid) seen = 1'b1;
      tick();
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL zero_len_start activity=%0b required=0", seen);
    end
    b_start_frame(16'd4, coef_01);
    b_num = 16'd1;
    b_coef = 36'hF_FFFF_FFFF;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    total++;
    if (b_busy !== 1'b1 || b_s_ready !== 1'b1) begin
      bad++;
      $display("FAIL start_in_acc busy=%0b s_ready=%0b required=1,1", b_busy, b_s_ready);
    end
    got_n = 0;
    for (int i = 0; i < 4; i++) b_send(pulse_x[i]);
    b_collect(0, 4);
    total++;
    if (got_n !== 4) begin
      bad++;
      $display("FAIL acc_start_count got=%0d required=4", got_n);
    end
    for (int i = 0; i < got_n; i++) begin
      total++;
      if (got_pow[i] !== 64'(exp_pow[i])) begin
        bad++;
        $display("FAIL acc_start_result%0d pow=%0d required=%0d", i, got_pow[i], exp_pow[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    b_start_frame(16'd4, coef_01);
    b_send(pulse_x[0]);
    b_send(pulse_x[1]);
    rst = 1'b1;
    #1;
    total++;
    if ({b_busy, b_s_ready, b_m_valid, b_frame_done, b_overflow} !== 5'b0 || b_m_power !== 64'd0) begin
      bad++;
      $display("FAIL midrun_reset flags=%b pow=%0d required=00000,0",
               {b_busy, b_s_ready, b_m_valid, b_frame_done, b_overflow}, b_m_power);
    end
    tick();
    rst = 1'b0;
    repeat (8) begin
      tick();
      if (b_busy || b_m_valid || b_frame_done) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL midrun_aborted activity=%0b required=0", seen);
    end
    got_n = 0;
    b_start_frame(16'd4, coef_01);
    for (int i = 0; i < 4; i++) b_send(pulse_x[i]);
    b_collect(0, 4);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= got_n || got_pow[i] !== 64'(exp_pow[i]) || got_chan[i] !== 1'(exp_chan[i])) begin
        bad++;
        $display("FAIL post_reset_result%0d pow=%0d required=%0d", i, got_pow[i], exp_pow[i]);
      end
    end
  endtask

  task automatic test_saturation();
    a_m_ready = 1'b0;
    a_start_frame(16'd64, 18'h1FFFF);
    for (int i = 0; i < 64; i++) a_send(16'h7FFF);
    a_wait_valid();
    total++;
    if (a_overflow !== EXP_OVF) begin
      bad++;
      $display("FAIL sat_overflow got=%0b required=%0b", a_overflow, EXP_OVF);
    end
`ifdef GOERTZEL_SAT_EN
    // Both states pinned at 2^17-1 -> p = 2*M^2 - 262140*M = 262142.
    total++;
    if (a_m_power !== 64'd262142) begin
      bad++;
      $display("FAIL sat_power got=%0d required=262142", a_m_power);
    end
`endif
    a_m_ready = 1'b1;
    tick();
    tick();
    a_start_frame(16'd4, 18'h0);
    total++;
    if (a_overflow !== 1'b0) begin
      bad++;
      $display("FAIL overflow_cleared got=%0b required=0", a_overflow);
    end
    for (int i = 0; i < 4; i++) a_send(pulse_x[i]);
    a_wait_valid();
    total++;
    if (a_m_power !== 64'd4 || a_overflow !== 1'b0) begin
      bad++;
      $display("FAIL after_sat_result pow=%0d ovf=%0b required=4,0", a_m_power, a_overflow);
    end
    tick();
  endtask

  initial begin
    #1;
    test_reset();
    test_single_pulse();
    test_single_dc();
    test_multi();
    test_backpressure();
    test_config_edges();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/goertzel_tdm.md
Name: goertzel_tdm

Overview:
- Parametrised, time-multiplexed Goertzel power engine; successor to the fixed two-bin Herzel datapath.
- Serves NCH input channels x NF frequency bins from one shared MAC, iterating one state slot per clock.
- Sits after the resync/scaling stage. Per frame of cfg_num_samp samples it streams NCH*NF power results over a valid/ready interface to the register block.

Parameters:
NCH, 2, number of input channels
NF, 2, number of frequency bins per channel
DW, 16, signed sample width per channel
CW, 18, signed coefficient width; coef = 2cos(w) in Q2.(CW-2), range [-2,2)
AW, 32, signed Goertzel state width
PW, 64, unsigned power output width
NSW, 16, sample-count width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  pulse: latch config, clear states, begin frame
cfg_num_samp  in  NSW  samples per frame
cfg_coef  in  NF*CW  per-bin coefficients, bin b at [b*CW +: CW]
s_valid  in  1  sample vector valid
s_ready  out  1  sample vector accepted when s_valid&&s_ready
s_data  in  NCH*DW  channel c at [c*DW +: DW]
m_valid  out  1  result valid
m_ready  in  1  result consumer ready
m_chan  out  $clog2(NCH) (min 1)  result channel
m_bin  out  $clog2(NF) (min 1)  result bin
m_power  out  PW  result power
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse after last result handshake
overflow  out  1  sticky state-saturation flag, cleared by start

Behaviour:
- Reset is asynchronous, active-high and applies to clk only. All outputs reset to 0. FSM resets to IDLE; state RAM/registers, counters and the latched config are cleared.
- FSM states: IDLE, ACC, RUN, FIN, OUT.
- IDLE:
  - start with cfg_num_samp!=0: latch cfg_num_samp and cfg_coef, zero all s1/s2, clear overflow, go to ACC.
  - start with cfg_num_samp==0: ignored; stay in IDLE.
  - start while busy: ignored.
- ACC: s_ready=1. On handshake, register s_data and go to RUN. s_ready is 0 in every other state.
- RUN: one slot per cycle, order channel-major, bin-minor (slot = c*NF+b), NCH*NF cycles.
  - Update: s0 = x_c + ((coef_b*s1) >>> (CW-2)) - s2; then s2<=s1, s1<=s0.
  - x_c is sign-extended to AW. The product is computed at AW+CW bits. Shift is arithmetic.
  - After the last slot, increment the sample counter. If count==cfg_num_samp go to FIN, else return to ACC.
  - Sustained throughput: 1 sample vector per NCH*NF+1 cycles.
- FIN / OUT: for each slot in the same order:
  - FIN takes 1 cycle: p = s1^2 + s2^2 - ((coef_b*s1) >>> (CW-2))*s2, computed at 2*AW+2 bits.
  - Negative p is clamped to 0. p > 2^PW-1 is clamped to 2^PW-1.
  - OUT: m_valid=1 with m_chan, m_bin, m_power held stable until m_ready.
  - On handshake: if more slots remain, go to FIN for the next slot. After the last slot, pulse frame_done, go to IDLE, and clear the states.
  - m_ready may be held high continuously; results then issue every 2 cycles.
- Overflow: any s0 outside the signed AW range sets overflow (behaviour per optional feature).
- Reset mid-frame aborts the frame: no partial results and no frame_done.
- cfg_* changes while busy have no effect until the next start.

Optional Feature:
GOERTZEL_SAT_EN
- Defined: s0 saturates to [-2^(AW-1), 2^(AW-1)-1]; overflow is set sticky when saturation occurs.
- Undefined: s0 wraps modulo 2^AW; overflow is tied to 0.

Decomposition:
- Shared package goertzel_pkg:
  - typedef of FSM state enum.
  - Coefficient fraction constant COEF_FRAC = CW-2.
  - Function sat_signed(value, width).
- One natural sub-module: goertzel_mac. It is combinational s0/p computation from x, coef, s1, s2 plus the saturation logic, and is reused in both RUN and FIN.
- State storage is an NCH*NF register array indexed by slot.

Test Plan:
- NCH=1, NF=1, coef=0, N=4, x={1,0,-1,0} -> one result, chan 0, bin 0, m_power=4; frame_done pulses one cycle after the handshake.
- Same config, x={1,1,1,1} -> m_power=0.
- NCH=2, NF=2, coef={0, 0x10000 (1.0)}, ch0 x={1,0,-1,0}, ch1 all 0, N=4 -> 4 results in order (0,0),(0,1),(1,0),(1,1). (0,0)=4; both ch1 results are 0.
- Backpressure: m_ready low for 10 cycles during OUT -> m_valid and all m_* fields stable; no result lost or duplicated.
- Config and control edge cases:
  - start with cfg_num_samp=0 -> busy stays 0, no results.
  - start during ACC -> ignored.
  - rst asserted mid-RUN -> all outputs 0, FSM in IDLE, next frame results identical to a clean run.
- GOERTZEL_SAT_EN, AW=18, coef=0x1FFFF (just under 2.0), x=32767 constant, N=64 -> overflow=1 and states clamp. Without the macro -> overflow=0.
